// File: rtl/mux_rr_scheduler.sv
// rtl/mux_rr_scheduler.sv - round-robin scheduler for a 32:1 mux (optional grant timeout: MUX_RR_TIMEOUT_EN)
module mux_rr_scheduler #(
    parameter int MAX_HOLD = 16
) (
    input  logic        Clock_In,
    input  logic        Reset_N_In,
    input  logic        Enable_In,
    input  logic [31:0] Request_In,
    input  logic        Done_In,
    output logic [4:0]  Select_Out,
    output logic        Mux_Enable_Out,
    output logic [31:0] Grant_Out,
    output logic        Grant_Valid_Out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARB     = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [4:0]  last_ptr;
    logic [4:0]  pick;
    logic [4:0]  scan_idx;
    logic        any_req;
    logic        hold_expired;

    // MAX_HOLD must fit the 8-bit hold counter and allow at least two grant cycles
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("mux_rr_scheduler: MAX_HOLD out of range 2..255");
    end

    assign any_req = |Request_In;

`ifdef MUX_RR_TIMEOUT_EN
    logic [7:0] hold_cnt;

    // Counts grant cycles; the grant is cut after MAX_HOLD cycles
    always_ff @(posedge Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            hold_cnt <= 8'd0;
        end else if (state == ARB) begin
            hold_cnt <= 8'd0;
        end else if (state == GRANT) begin
            hold_cnt <= hold_cnt + 8'd1;
        end
    end

    assign hold_expired = (hold_cnt == 8'(MAX_HOLD - 1));
`else
    assign hold_expired = 1'b0;
`endif

    // Round-robin search: first requester at or after last_ptr+1, wrapping past 31;
    // scanning from the far end lets the nearest hit win
    always_comb begin
        pick     = last_ptr;
        scan_idx = last_ptr;
        for (int k = 32; k >= 1; k--) begin
            scan_idx = last_ptr + 5'(k);
            if (Request_In[scan_idx]) begin
                pick = scan_idx;
            end
        end
    end

    // State register
    always_ff @(posedge Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; all GRANT exit causes collapse into one transition
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (Enable_In && any_req) begin
                    state_next = ARB;
                end
            end
            ARB: begin
                if (Enable_In && any_req) begin
                    state_next = GRANT;
                end else begin
                    state_next = IDLE;
                end
            end
            GRANT: begin
                if (Done_In || !Request_In[Select_Out] || !Enable_In || hold_expired) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (Enable_In && any_req) begin
                    state_next = ARB;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Select latches the winner in ARB; the pointer advances when the grant is released
    always_ff @(posedge Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            Select_Out <= 5'd0;
            last_ptr   <= 5'd31;
        end else begin
            if (state == ARB && state_next == GRANT) begin
                Select_Out <= pick;
            end
            if (state == RELEASE) begin
                last_ptr <= Select_Out;
            end
        end
    end

    assign Grant_Valid_Out = (state == GRANT);
    assign Mux_Enable_Out  = (state == GRANT);
    assign Grant_Out       = Grant_Valid_Out ? (32'd1 << Select_Out) : 32'd0;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// tb/tb_mux_rr_scheduler.sv - self-checking bench for mux_rr_scheduler
module tb_mux_rr_scheduler;

    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [31:0] req = 32'd0;
    logic        done = 1'b0;
    logic [4:0]  sel;
    logic        mux_en;
    logic [31:0] grant;
    logic        gvalid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          rst;
        bit          en;
        logic [31:0] req;
        bit          done;
        bit          exp_v;
        logic [4:0]  exp_s;
    } vec_t;

    typedef struct {
        bit         v;
        logic [4:0] s;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    mux_rr_scheduler #(.MAX_HOLD(HOLD)) dut (
        .Clock_In        (clk),
        .Reset_N_In      (rst_n),
        .Enable_In       (en),
        .Request_In      (req),
        .Done_In         (done),
        .Select_Out      (sel),
        .Mux_Enable_Out  (mux_en),
        .Grant_Out       (grant),
        .Grant_Valid_Out (gvalid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (checks %0d)", checks);
        $fatal(1);
    end

    function automatic void add(bit r, bit e, logic [31:0] q, bit d, bit v, logic [4:0] s);
        vec_t t;
        t.rst = r; t.en = e; t.req = q; t.done = d; t.exp_v = v; t.exp_s = s;
        vecs.push_back(t);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(string tag, bit v, logic [4:0] s);
        logic [31:0] g;
        g = v ? (32'd1 << s) : 32'd0;
        check({tag, "_valid"}, {31'd0, gvalid}, {31'd0, v});
        check({tag, "_mux_en"}, {31'd0, mux_en}, {31'd0, v});
        check({tag, "_grant"}, grant, g);
        check({tag, "_sel"}, {27'd0, sel}, {27'd0, s});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 32'd0;
        done  = 1'b0;
        #1;
        check_outputs("reset", 1'b0, 5'd0);
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        exp_t e;
        int   run;
        int   guard;

        // A: single source, grant after two edges, Done ends it
        add(1, 1, 32'h1, 0, 0, 5'd0);
        add(0, 1, 32'h1, 0, 1, 5'd0);
        add(0, 1, 32'h1, 0, 1, 5'd0);
        add(0, 1, 32'h1, 0, 1, 5'd0);
        add(0, 1, 32'h1, 1, 0, 5'd0);
        add(0, 1, 32'h0, 0, 0, 5'd0);
        add(0, 0, 32'h1, 0, 0, 5'd0);
        // B: rotation 0,4,31,0, last release with all exits coinciding
        add(1, 1, 32'h8000_0011, 0, 0, 5'd0);
        add(0, 1, 32'h8000_0011, 0, 1, 5'd0);
        add(0, 1, 32'h8000_0011, 1, 0, 5'd0);
        add(0, 1, 32'h8000_0011, 0, 0, 5'd0);
        add(0, 1, 32'h8000_0011, 0, 1, 5'd4);
        add(0, 1, 32'h8000_0011, 1, 0, 5'd4);
        add(0, 1, 32'h8000_0011, 0, 0, 5'd4);
        add(0, 1, 32'h8000_0011, 0, 1, 5'd31);
        add(0, 1, 32'h8000_0011, 1, 0, 5'd31);
        add(0, 1, 32'h8000_0011, 0, 0, 5'd31);
        add(0, 1, 32'h8000_0011, 0, 1, 5'd0);
        add(0, 0, 32'h0,         1, 0, 5'd0);
        add(0, 0, 32'h0,         0, 0, 5'd0);
        // C: request drop, Done ignored in IDLE, sole re-grant, enable drop, ARB abort
        add(1, 1, 32'h20, 0, 0, 5'd0);
        add(0, 1, 32'h20, 0, 1, 5'd5);
        add(0, 1, 32'h20, 0, 1, 5'd5);
        add(0, 1, 32'h0,  0, 0, 5'd5);
        add(0, 1, 32'h0,  1, 0, 5'd5);
        add(0, 1, 32'h20, 1, 0, 5'd5);
        add(0, 1, 32'h20, 0, 1, 5'd5);
        add(0, 0, 32'h20, 0, 0, 5'd5);
        add(0, 0, 32'h20, 0, 0, 5'd5);
        add(0, 0, 32'h20, 0, 0, 5'd5);
        add(0, 1, 32'h20, 0, 0, 5'd5);
        add(0, 1, 32'h20, 0, 1, 5'd5);
        add(0, 1, 32'h20, 1, 0, 5'd5);
        add(0, 1, 32'h20, 0, 0, 5'd5);
        add(0, 1, 32'h0,  0, 0, 5'd5);
        add(0, 1, 32'h0,  0, 0, 5'd5);

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) begin
                do_reset();
            end
            en   = vecs[i].en;
            req  = vecs[i].req;
            done = vecs[i].done;
            e.v  = vecs[i].exp_v;
            e.s  = vecs[i].exp_s;
            sb.push_back(e);
            step();
            e = sb.pop_front();
            check_outputs($sformatf("vec%0d", i), e.v, e.s);
        end

        // Asynchronous reset in the middle of a grant, then source 0 wins first
        do_reset();
        en  = 1'b1;
        req = 32'h8;
        step();
        step();
        check_outputs("pre_rst_grant", 1'b1, 5'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("async_rst", 1'b0, 5'd0);
        step();
        rst_n = 1'b1;
        req   = 32'h9;
        step();
        check_outputs("post_rst_arb", 1'b0, 5'd0);
        step();
        check_outputs("post_rst_grant", 1'b1, 5'd0);

        // Held request with no Done: timeout (if built in) or indefinite grant
        do_reset();
        en  = 1'b1;
        req = 32'hC;
        step();
        step();
        check_outputs("hold_grant", 1'b1, 5'd2);
        run   = 1;
        guard = 0;
        while (guard < 12) begin
            step();
            guard++;
            if (gvalid) run++;
            else break;
        end
`ifdef MUX_RR_TIMEOUT_EN
        check("timeout_cycles", run, HOLD);
        check_outputs("timeout_release", 1'b0, 5'd2);
        step();
        step();
        check_outputs("timeout_next", 1'b1, 5'd3);
`else
        check("no_timeout_cycles", run, 13);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
